// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared mode type and channel-select width helper for the programmable divider
package clk_div_pkg;

    typedef enum logic {DIV_TOGGLE = 1'b0, DIV_PULSE = 1'b1} div_mode_t;

    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel with shadowed divisor/mode applied at terminal count or while idle
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int W           = 16,
    parameter int DEFAULT_DIV = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_div,
    input  div_mode_t    load_mode,
    output logic         pending,
    output logic         tick,
    output logic         y
);

    logic [W-1:0] count;
    logic [W-1:0] div;
    logic [W-1:0] shadow_div;
    div_mode_t    mode;
    div_mode_t    shadow_mode;
    logic         term;
    logic         apply;

    always_comb begin
        term  = en && (count == div);
        apply = pending && (term || !en);
    end

    // Later assignments win: apply overrides the count step, and a pulse->toggle switch clears y.
    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= '0;
            div         <= W'(DEFAULT_DIV);
            mode        <= DIV_TOGGLE;
            shadow_div  <= '0;
            shadow_mode <= DIV_TOGGLE;
            pending     <= 1'b0;
            tick        <= 1'b0;
            y           <= 1'b0;
        end else begin
            tick <= term;
            if (en) begin
                count <= term ? '0 : count + W'(1);
                y     <= (mode == DIV_PULSE) ? term : (y ^ term);
            end else if (mode == DIV_PULSE) begin
                y <= 1'b0;
            end
            if (apply) begin
                div     <= shadow_div;
                mode    <= shadow_mode;
                count   <= '0;
                pending <= 1'b0;
                if (mode == DIV_PULSE && shadow_mode == DIV_TOGGLE) y <= 1'b0;
            end
            if (load) begin
                shadow_div  <= load_div;
                shadow_mode <= load_mode;
                pending     <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog: multi-channel programmable clock/tick divider with a valid/ready divisor load port
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int W           = 16,
    parameter int DEFAULT_DIV = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [CHANNELS-1:0]           en,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [chan_w(CHANNELS)-1:0]   cfg_ch,
    input  logic [W-1:0]                  cfg_div,
    input  logic                          cfg_mode,
    output logic [CHANNELS-1:0]           tick,
    output logic [CHANNELS-1:0]           y
);

    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] load;

    // Out-of-range channels are always ready so their loads are swallowed.
    always_comb begin
        cfg_ready = 1'b1;
        load      = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (int'(cfg_ch) == i) cfg_ready = !pending[i];
        for (int i = 0; i < CHANNELS; i++)
            load[i] = cfg_valid && cfg_ready && (int'(cfg_ch) == i);
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        clk_div_chan #(
            .W           (W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .en        (en[g]),
            .load      (load[g]),
            .load_div  (cfg_div),
            .load_mode (div_mode_t'(cfg_mode)),
            .pending   (pending[g]),
            .tick      (tick[g]),
            .y         (y[g])
        );
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed checks of reset, divisor loads, mode switches, enable gating and reset-abort
module tb_clk_div_prog;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [0:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic        cfg_mode;
    logic [1:0]  tick;
    logic [1:0]  y;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n;
    logic        y_hold;

    clk_div_prog #(.CHANNELS(2), .W(16), .DEFAULT_DIV(255)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_mode  (cfg_mode),
        .tick      (tick),
        .y         (y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    // Returns the number of edges until tick[ch] rises, or -1 if the budget runs out.
    task automatic wait_tick(input int ch, input int budget, output int cnt);
        cnt = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (tick[ch]) begin
                cnt = i;
                break;
            end
        end
    endtask

    task automatic cfg(input logic ch, input logic [15:0] d, input logic m);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = d;
        cfg_mode  = m;
    endtask

    initial begin
        reset = 1'b1; en = 2'b11; cfg_valid = 1'b0; cfg_ch = 1'b0; cfg_div = '0; cfg_mode = 1'b0;
        step();
        reset = 1'b0;
        chk("rst_tick", tick, 0);
        chk("rst_y", y, 0);
        chk("rst_ready", cfg_ready, 1);
        // default divisor: tick every 256 edges, y toggles at each tick
        steps(255);
        chk("t1_pre_tick", tick, 0);
        step();
        chk("t1_tick", tick, 2'b11);
        chk("t1_y_hi", y, 2'b11);
        steps(255);
        chk("t1_y_hold", y, 2'b11);
        chk("t1_no_tick", tick, 0);
        step();
        chk("t1_tick2", tick, 2'b11);
        chk("t1_y_lo", y, 0);
        // ch0 D=3 toggle, applied at the end of the running 256-cycle period
        cfg(1'b0, 16'd3, 1'b0);
        step();
        cfg_valid = 1'b0;
        #1;
        chk("t2_ready_ch0", cfg_ready, 0);
        cfg_ch = 1'b1;
        #1;
        chk("t2_ready_ch1", cfg_ready, 1);
        wait_tick(0, 300, n);
        chk("t2_apply_n", n, 255);
        chk("t2_apply_y", y[0], 1);
        cfg_ch = 1'b0;
        #1;
        chk("t2_ready_after", cfg_ready, 1);
        wait_tick(0, 20, n);
        chk("t2_per1", n, 4);
        chk("t2_y1", y[0], 0);
        steps(3);
        chk("t2_y_low_run", y[0], 0);
        step();
        chk("t2_per2_tick", tick[0], 1);
        chk("t2_y2", y[0], 1);
        // ch1 D=0 pulse, then D=2 toggle
        cfg(1'b1, 16'd0, 1'b1);
        step();
        cfg_valid = 1'b0;
        wait_tick(1, 600, n);
        chk("t3_apply_seen", n > 0, 1);
        step();
        chk("t3_d0_tick_a", tick[1], 1);
        chk("t3_d0_y_a", y[1], 1);
        step();
        chk("t3_d0_tick_b", tick[1], 1);
        chk("t3_d0_y_b", y[1], 1);
        cfg(1'b1, 16'd2, 1'b0);
        step();
        cfg_valid = 1'b0;
        #1;
        chk("t3_ready_pend", cfg_ready, 0);
        chk("t3_pulse_y", y[1], 1);
        step();
        chk("t3_apply_tick", tick[1], 1);
        chk("t3_forced_y0", y[1], 0);
        chk("t3_ready_clr", cfg_ready, 1);
        wait_tick(1, 20, n);
        chk("t3_per1", n, 3);
        chk("t3_y1", y[1], 1);
        wait_tick(1, 20, n);
        chk("t3_per2", n, 3);
        chk("t3_y2", y[1], 0);
        // load ch0 on its terminal-count cycle: old D=3 kept for one more period
        wait_tick(0, 20, n);
        chk("t4_sync", n > 0, 1);
        steps(3);
        cfg(1'b0, 16'd5, 1'b0);
        step();
        chk("t4_term_tick", tick[0], 1);
        chk("t4_ready_low", cfg_ready, 0);
        cfg(1'b0, 16'd7, 1'b0);
        #1;
        chk("t4_stall_ready", cfg_ready, 0);
        step();
        cfg(1'b1, 16'd2, 1'b0);
        #1;
        chk("t4_other_ready", cfg_ready, 1);
        step();
        cfg_valid = 1'b0;
        #1;
        chk("t4_other_pend", cfg_ready, 0);
        wait_tick(0, 20, n);
        chk("t4_old_period", n, 2);
        cfg_ch = 1'b0;
        #1;
        chk("t4_ready_ch0", cfg_ready, 1);
        wait_tick(0, 20, n);
        chk("t4_new_period", n, 6);
        // en low mid-count with a pending load
        cfg(1'b0, 16'd9, 1'b0);
        step();
        cfg_valid = 1'b0;
        wait_tick(0, 20, n);
        chk("t5_apply9", n, 5);
        steps(3);
        cfg(1'b0, 16'd4, 1'b0);
        step();
        cfg_valid = 1'b0;
        step();
        y_hold = y[0];
        en[0] = 1'b0;
        step();
        chk("t5_dis_tick", tick[0], 0);
        chk("t5_dis_y", y[0], y_hold);
        chk("t5_apply_idle", cfg_ready, 1);
        steps(12);
        chk("t5_idle_tick", tick[0], 0);
        chk("t5_idle_y", y[0], y_hold);
        en[0] = 1'b1;
        wait_tick(0, 20, n);
        chk("t5_resume", n, 5);
        chk("t5_resume_y", y[0], !y_hold);
        wait_tick(0, 20, n);
        chk("t5_per", n, 5);
        // reset with a concurrent load request
        steps(2);
        cfg(1'b1, 16'd7, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        cfg_valid = 1'b0;
        chk("t6_tick", tick, 0);
        chk("t6_y", y, 0);
        chk("t6_ready1", cfg_ready, 1);
        cfg_ch = 1'b0;
        #1;
        chk("t6_ready0", cfg_ready, 1);
        wait_tick(0, 300, n);
        chk("t6_default_n", n, 256);
        chk("t6_both_tick", tick, 2'b11);
        chk("t6_y", y, 2'b11);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
